dlatch_bank: RTL and testbench

- Parametrised, clocked successor to the single-bit NMOS static latch.
- Provides CHANNELS independent latches, each WIDTH bits wide. Each channel has true and inverted outputs.
- Two selectable capture modes: transparent and edge-registered.
- Optional modelling of dynamic-node charge decay: a channel not rewritten for DECAY_CYCLES clocks loses its value.
- Used wherever chip netlists hold multi-bit latched state (register files, shifter taps, OAM/palette holding latches), so the design avoids per-bit asynchronous tri-state nodes.

---
 rtl/dlatch_pkg.sv | 29 ++
 rtl/dlatch_chan.sv | 93 +++++++++
 rtl/dlatch_bank.sv | 56 +++++
 tb/tb_dlatch_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dlatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dlatch_pkg
//  Description : Shared definitions for the dlatch_bank latch array:
//                capture-mode encodings and a width helper for the
//                decay age counter.
//  Revision    : 1.0  initial release
// ============================================================================
package dlatch_pkg;

    // Capture mode encodings for the MODE parameter
    localparam int DL_TRANSPARENT = 0;   // q follows d while en=1
    localparam int DL_REGISTERED  = 1;   // q updates only at the rising edge

    // Ceiling of log2(value); clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    // Written as a bounded loop so it elaborates as a constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : dlatch_pkg
`default_nettype wire

// File: rtl/dlatch_chan.sv
`default_nettype none
// ============================================================================
//  Module      : dlatch_chan
//  Description : One latch channel of dlatch_bank. Holds a WIDTH-bit value
//                captured on the rising clock edge, presents it either
//                transparently (d bypasses the store while en=1) or
//                registered, and optionally models dynamic-node decay by
//                forcing DECAY_VALUE after DECAY_CYCLES edges without a
//                write.
//  Revision    : 1.0  initial release
// ============================================================================
module dlatch_chan
    import dlatch_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               MODE         = DL_TRANSPARENT,
    parameter int               DECAY_CYCLES = 0,
    parameter logic [WIDTH-1:0] DECAY_VALUE  = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             valid,
    output logic             decay_evt
);

    logic [WIDTH-1:0] store;
    logic             expire;   // this edge is the one where the value decays

    generate
        if (DECAY_CYCLES > 0) begin : g_decay
            localparam int               AGE_W    = clog2(DECAY_CYCLES + 1);
            localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(DECAY_CYCLES);
            localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DECAY_CYCLES - 1);

            logic [AGE_W-1:0] age;

            // Idle-edge counter: cleared by a write, saturates once decayed
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age <= '0;
                end else if (en) begin
                    age <= '0;
                end else if (age != AGE_MAX) begin
                    age <= age + AGE_W'(1);
                end
            end

            // A write on the expiry edge wins, so expiry requires en=0
            assign expire = !en && (age == AGE_LAST);
        end else begin : g_no_decay
            assign expire = 1'b0;
        end
    endgenerate

    // Stored value, written-flag and the one-cycle decay pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store     <= RESET_VALUE;
            valid     <= 1'b0;
            decay_evt <= 1'b0;
        end else begin
            decay_evt <= expire;
            if (en) begin
                store <= d;
                valid <= 1'b1;
            end else if (expire) begin
                store <= DECAY_VALUE;
                valid <= 1'b0;
            end
        end
    end

    generate
        if (MODE == DL_REGISTERED) begin : g_registered
            // No combinational path from d to q
            assign q = store;
        end else begin : g_transparent
            // Bypass is gated by reset so q shows RESET_VALUE during reset
            // even when a write is in progress. Between edges, dropping en
            // reverts q to the value captured at the last enabled edge.
            assign q = (en && rst_n) ? d : store;
        end
    endgenerate

    assign nq = ~q;

endmodule : dlatch_chan
`default_nettype wire

// File: rtl/dlatch_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dlatch_bank
//  Description : CHANNELS independent WIDTH-bit clocked latches with true and
//                inverted outputs, selectable transparent/registered capture
//                and optional charge-decay modelling. Clocked replacement for
//                per-bit asynchronous NMOS static latches.
//                Note for users of MODE=0: if en falls between edges, q
//                reverts to the value captured at the last enabled edge,
//                not to the last value seen on d.
//  Revision    : 1.0  initial release
// ============================================================================
module dlatch_bank
    import dlatch_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               CHANNELS     = 4,
    parameter int               MODE         = DL_TRANSPARENT,
    parameter int               DECAY_CYCLES = 0,
    parameter logic [WIDTH-1:0] DECAY_VALUE  = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                      CLK,
    input  logic                      n_RES,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] nq,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       decay_evt
);

    // One fully independent channel per slice of the packed buses
    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            dlatch_chan #(
                .WIDTH        (WIDTH),
                .MODE         (MODE),
                .DECAY_CYCLES (DECAY_CYCLES),
                .DECAY_VALUE  (DECAY_VALUE),
                .RESET_VALUE  (RESET_VALUE)
            ) u_chan (
                .clk       (CLK),
                .rst_n     (n_RES),
                .en        (en[k]),
                .d         (d[k*WIDTH +: WIDTH]),
                .q         (q[k*WIDTH +: WIDTH]),
                .nq        (nq[k*WIDTH +: WIDTH]),
                .valid     (valid[k]),
                .decay_evt (decay_evt[k])
            );
        end
    endgenerate

endmodule : dlatch_bank
`default_nettype wire

// File: tb/tb_dlatch_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dlatch_bank
//  Description : Self-checking bench for dlatch_bank. Three instances share
//                clock and reset: [0] registered without decay, [1]
//                transparent without decay, [2] registered with
//                DECAY_CYCLES=3. Expected values are queued as stimulus is
//                driven and popped when the DUT output is sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dlatch_bank;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] RST_Q = 32'h5A5A5A5A;

    typedef struct {
        logic [CH-1:0] en;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic [CH-1:0] v;
        logic [CH-1:0] e;
    } step_t;

    logic          clk;
    logic          n_res;
    logic [CH-1:0] en_a [3];
    logic [DW-1:0] d_a  [3];
    logic [DW-1:0] q_a  [3];
    logic [DW-1:0] nq_a [3];
    logic [CH-1:0] v_a  [3];
    logic [CH-1:0] e_a  [3];

    int    tests = 0;
    int    fails = 0;
    step_t sbq[$];

    dlatch_bank #(.WIDTH(8), .CHANNELS(CH), .MODE(1), .DECAY_CYCLES(0),
                  .DECAY_VALUE(8'h00), .RESET_VALUE(8'h5A)) dut_reg (
        .CLK(clk), .n_RES(n_res), .en(en_a[0]), .d(d_a[0]),
        .q(q_a[0]), .nq(nq_a[0]), .valid(v_a[0]), .decay_evt(e_a[0]));

    dlatch_bank #(.WIDTH(8), .CHANNELS(CH), .MODE(0), .DECAY_CYCLES(0),
                  .DECAY_VALUE(8'h00), .RESET_VALUE(8'h5A)) dut_tr (
        .CLK(clk), .n_RES(n_res), .en(en_a[1]), .d(d_a[1]),
        .q(q_a[1]), .nq(nq_a[1]), .valid(v_a[1]), .decay_evt(e_a[1]));

    dlatch_bank #(.WIDTH(8), .CHANNELS(CH), .MODE(1), .DECAY_CYCLES(3),
                  .DECAY_VALUE(8'h00), .RESET_VALUE(8'h5A)) dut_dec (
        .CLK(clk), .n_RES(n_res), .en(en_a[2]), .d(d_a[2]),
        .q(q_a[2]), .nq(nq_a[2]), .valid(v_a[2]), .decay_evt(e_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            en_a[i] = 4'hF;
        end
        d_a[0] = 32'h12345678; d_a[1] = 32'h87654321; d_a[2] = 32'hCAFEF00D;
        tick();
        #2 n_res = 1'b0;           // asserted mid-cycle with writes still enabled
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (q_a[i] !== RST_Q) begin fails++; $display("FAIL reset_q[%0d]: got %h expected %h", i, q_a[i], RST_Q); end
            tests++; if (nq_a[i] !== ~RST_Q) begin fails++; $display("FAIL reset_nq[%0d]: got %h expected %h", i, nq_a[i], ~RST_Q); end
            tests++; if (v_a[i] !== 4'h0) begin fails++; $display("FAIL reset_valid[%0d]: got %b expected 0000", i, v_a[i]); end
            tests++; if (e_a[i] !== 4'h0) begin fails++; $display("FAIL reset_evt[%0d]: got %b expected 0000", i, e_a[i]); end
        end
        tick();                    // edge while reset is still held
        for (int i = 0; i < 3; i++) begin
            tests++; if (q_a[i] !== RST_Q) begin fails++; $display("FAIL reset_hold_q[%0d]: got %h expected %h", i, q_a[i], RST_Q); end
            en_a[i] = 4'h0;
        end
        n_res = 1'b1;
        tick();                    // release is sampled here
        for (int i = 0; i < 3; i++) begin
            tests++; if (q_a[i] !== RST_Q) begin fails++; $display("FAIL release_q[%0d]: got %h expected %h", i, q_a[i], RST_Q); end
            tests++; if (v_a[i] !== 4'h0) begin fails++; $display("FAIL release_valid[%0d]: got %b expected 0000", i, v_a[i]); end
        end
    endtask

    task automatic test_registered();
        step_t plan[$];
        step_t x;
        plan.push_back(step_t'{en:4'b0100, d:32'h113C2233, q:32'h5A3C5A5A, v:4'b0100, e:4'h0});
        plan.push_back(step_t'{en:4'b0000, d:32'hFFFFFFFF, q:32'h5A3C5A5A, v:4'b0100, e:4'h0});
        for (int s = 0; s < plan.size(); s++) begin
            en_a[0] = plan[s].en; d_a[0] = plan[s].d;
            sbq.push_back(plan[s]);
            if (s == 0) begin
                #2;
                tests++; if (q_a[0] !== RST_Q) begin fails++; $display("FAIL reg_no_bypass: got %h expected %h", q_a[0], RST_Q); end
            end
            tick();
            x = sbq.pop_front();
            tests++; if (q_a[0] !== x.q) begin fails++; $display("FAIL reg_q step %0d: got %h expected %h", s, q_a[0], x.q); end
            tests++; if (nq_a[0] !== ~x.q) begin fails++; $display("FAIL reg_nq step %0d: got %h expected %h", s, nq_a[0], ~x.q); end
            tests++; if (v_a[0] !== x.v) begin fails++; $display("FAIL reg_valid step %0d: got %b expected %b", s, v_a[0], x.v); end
            tests++; if (e_a[0] !== x.e) begin fails++; $display("FAIL reg_evt step %0d: got %b expected %b", s, e_a[0], x.e); end
        end
    endtask

    task automatic test_transparent();
        step_t plan[$];
        step_t x;
        // Entries 0/1 are mid-cycle observations, 2/3 follow rising edges
        plan.push_back(step_t'{en:4'b0001, d:32'h00000011, q:32'h5A5A5A11, v:4'b0000, e:4'h0});
        plan.push_back(step_t'{en:4'b0001, d:32'h00000022, q:32'h5A5A5A22, v:4'b0000, e:4'h0});
        plan.push_back(step_t'{en:4'b0000, d:32'h000000FF, q:32'h5A5A5A22, v:4'b0001, e:4'h0});
        plan.push_back(step_t'{en:4'b0000, d:32'h000000FF, q:32'h5A5A5A22, v:4'b0001, e:4'h0});
        for (int s = 0; s < plan.size(); s++) begin
            en_a[1] = plan[s].en; d_a[1] = plan[s].d;
            sbq.push_back(plan[s]);
            if (s < 2) #2; else tick();
            x = sbq.pop_front();
            tests++; if (q_a[1] !== x.q) begin fails++; $display("FAIL tr_q step %0d: got %h expected %h", s, q_a[1], x.q); end
            tests++; if (nq_a[1] !== ~x.q) begin fails++; $display("FAIL tr_nq step %0d: got %h expected %h", s, nq_a[1], ~x.q); end
            tests++; if (v_a[1] !== x.v) begin fails++; $display("FAIL tr_valid step %0d: got %b expected %b", s, v_a[1], x.v); end
            tests++; if (e_a[1] !== x.e) begin fails++; $display("FAIL tr_evt step %0d: got %b expected %b", s, e_a[1], x.e); end
            if (s == 1) begin
                tick();            // captures 8'h22 on channel 0
            end
        end
    endtask

    task automatic test_decay();
        step_t plan[$];
        step_t x;
        plan.push_back(step_t'{en:4'hF, d:32'h44337711, q:32'h44337711, v:4'hF, e:4'h0});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h44337711, v:4'hF, e:4'h0});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h44337711, v:4'hF, e:4'h0});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h00000000, v:4'h0, e:4'hF});
        for (int k = 0; k < 10; k++) begin
            plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h00000000, v:4'h0, e:4'h0});
        end
        for (int s = 0; s < plan.size(); s++) begin
            en_a[2] = plan[s].en; d_a[2] = plan[s].d;
            sbq.push_back(plan[s]);
            tick();
            x = sbq.pop_front();
            tests++; if (q_a[2] !== x.q) begin fails++; $display("FAIL decay_q step %0d: got %h expected %h", s, q_a[2], x.q); end
            tests++; if (v_a[2] !== x.v) begin fails++; $display("FAIL decay_valid step %0d: got %b expected %b", s, v_a[2], x.v); end
            tests++; if (e_a[2] !== x.e) begin fails++; $display("FAIL decay_evt step %0d: got %b expected %b", s, e_a[2], x.e); end
        end
    endtask

    task automatic test_collision();
        step_t plan[$];
        step_t x;
        plan.push_back(step_t'{en:4'hF,    d:32'h55667788, q:32'h55667788, v:4'hF,    e:4'h0});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h55667788, v:4'hF,    e:4'h0});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h55667788, v:4'hF,    e:4'h0});
        plan.push_back(step_t'{en:4'b0010, d:32'h00009900, q:32'h00009900, v:4'b0010, e:4'b1101});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h00009900, v:4'b0010, e:4'h0});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h00009900, v:4'b0010, e:4'h0});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h00000000, v:4'h0,    e:4'b0010});
        plan.push_back(step_t'{en:4'h0,    d:32'h0,        q:32'h00000000, v:4'h0,    e:4'h0});
        for (int s = 0; s < plan.size(); s++) begin
            en_a[2] = plan[s].en; d_a[2] = plan[s].d;
            sbq.push_back(plan[s]);
            tick();
            x = sbq.pop_front();
            tests++; if (q_a[2] !== x.q) begin fails++; $display("FAIL coll_q step %0d: got %h expected %h", s, q_a[2], x.q); end
            tests++; if (nq_a[2] !== ~x.q) begin fails++; $display("FAIL coll_nq step %0d: got %h expected %h", s, nq_a[2], ~x.q); end
            tests++; if (v_a[2] !== x.v) begin fails++; $display("FAIL coll_valid step %0d: got %b expected %b", s, v_a[2], x.v); end
            tests++; if (e_a[2] !== x.e) begin fails++; $display("FAIL coll_evt step %0d: got %b expected %b", s, e_a[2], x.e); end
        end
    endtask

    task automatic test_back_to_back();
        step_t plan[$];
        step_t x;
        en_a[2] = 4'hF; d_a[2] = 32'hDEADBEEF;
        tick();
        tests++; if (q_a[2] !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_write_q: got %h expected DEADBEEF", q_a[2]); end
        en_a[2] = 4'h0;
        tick();                    // one idle edge: age is now non-zero
        #2 n_res = 1'b0;
        #1;
        tests++; if (q_a[2] !== RST_Q) begin fails++; $display("FAIL b2b_reset_q: got %h expected %h", q_a[2], RST_Q); end
        tests++; if (v_a[2] !== 4'h0) begin fails++; $display("FAIL b2b_reset_valid: got %b expected 0000", v_a[2]); end
        tick();
        n_res = 1'b1;
        // Age must restart from zero: decay lands on the third idle edge
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:RST_Q,        v:4'h0, e:4'h0});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:RST_Q,        v:4'h0, e:4'h0});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h00000000, v:4'h0, e:4'hF});
        plan.push_back(step_t'{en:4'h0, d:32'h0, q:32'h00000000, v:4'h0, e:4'h0});
        for (int s = 0; s < plan.size(); s++) begin
            en_a[2] = plan[s].en; d_a[2] = plan[s].d;
            sbq.push_back(plan[s]);
            tick();
            x = sbq.pop_front();
            tests++; if (q_a[2] !== x.q) begin fails++; $display("FAIL b2b_q step %0d: got %h expected %h", s, q_a[2], x.q); end
            tests++; if (v_a[2] !== x.v) begin fails++; $display("FAIL b2b_valid step %0d: got %b expected %b", s, v_a[2], x.v); end
            tests++; if (e_a[2] !== x.e) begin fails++; $display("FAIL b2b_evt step %0d: got %b expected %b", s, e_a[2], x.e); end
        end
    endtask

    initial begin
        n_res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_a[i] = 4'h0;
            d_a[i]  = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 n_res = 1'b1;
        test_reset();
        test_registered();
        test_transparent();
        test_decay();
        test_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule : tb_dlatch_bank
`default_nettype wire
